// File: rtl/shiftrows_gather.sv
// shiftrows_gather: collects four AES state columns and presents them ShiftRows-permuted (or unshifted when round 0)
module shiftrows_gather (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  col_in,
  input  logic         col_valid,
  output logic         col_ready,
  input  logic [3:0]   Round,
  output logic [127:0] state_out,
  output logic         state_valid,
  input  logic         state_ready,
  output logic [1:0]   col_idx
);
  typedef enum logic {COLLECT, FULL} state_t;
  state_t state;
  logic [3:0][31:0] cols;
  logic [3:0] round_q;
  logic accept;
  logic shift;
  assign accept = col_valid && col_ready;
  assign shift = |round_q;
  // Column gathering FSM; round number is captured with column 0 only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= COLLECT;
      col_idx     <= 2'd0;
      cols        <= '0;
      round_q     <= 4'd0;
      col_ready   <= 1'b1;
      state_valid <= 1'b0;
    end else if (state == COLLECT) begin
      if (accept) begin
        cols[col_idx] <= col_in;
        col_idx       <= col_idx + 2'd1;
        if (col_idx == 2'd0) round_q <= Round;
        if (col_idx == 2'd3) begin
          state       <= FULL;
          col_ready   <= 1'b0;
          state_valid <= 1'b1;
        end
      end
    end else if (state_ready) begin
      state       <= COLLECT;
      col_ready   <= 1'b1;
      state_valid <= 1'b0;
    end
  end
  // Output byte (row r, column c) comes from buffered column c+r when shifting, else column c
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign state_out[127-32*c-8*r -: 8] = shift ? cols[(c+r)%4][31-8*r -: 8] : cols[c][31-8*r -: 8];
    end
  end
endmodule

// File: tb/tb_shiftrows_gather.sv
// tb_shiftrows_gather: directed checks of column gathering, ShiftRows, backpressure and reset
module tb_shiftrows_gather;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  col_in;
  logic         col_valid;
  logic         col_ready;
  logic [3:0]   Round;
  logic [127:0] state_out;
  logic         state_valid;
  logic         state_ready;
  logic [1:0]   col_idx;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] fips [4] = '{32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230};
  logic [31:0] byp  [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] BYP_OUT  = 128'h00112233445566778899aabbccddeeff;

  shiftrows_gather dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .col_valid(col_valid), .col_ready(col_ready),
    .Round(Round), .state_out(state_out), .state_valid(state_valid), .state_ready(state_ready),
    .col_idx(col_idx)
  );

  always #5 clk = ~clk;

  // Stimulus helpers start and end on a falling edge
  task automatic send4(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2,
                       input logic [31:0] c3, input logic [3:0] rnd);
    logic [31:0] c [4];
    c = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      col_valid = 1'b1;
      col_in = c[i];
      Round = rnd;
      @(negedge clk);
    end
    col_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    col_valid = 1'b0;
    col_in = '0;
    Round = 4'd0;
    state_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    total_cnt++; if (state_out !== 128'h0) $display("FAIL reset_out got %h want %h", state_out, 128'h0); else pass_cnt++;
    total_cnt++; if (state_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", state_valid); else pass_cnt++;
    total_cnt++; if (col_idx !== 2'd0) $display("FAIL reset_idx got %0d want 0", col_idx); else pass_cnt++;
    total_cnt++; if (col_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", col_ready); else pass_cnt++;
  endtask

  task automatic test_fips();
    state_ready = 1'b1;
    send4(fips[0], fips[1], fips[2], fips[3], 4'd1);
    total_cnt++; if (state_valid !== 1'b1) $display("FAIL fips_valid got %b want 1", state_valid); else pass_cnt++;
    total_cnt++; if (state_out !== FIPS_OUT) $display("FAIL fips_out got %h want %h", state_out, FIPS_OUT); else pass_cnt++;
    total_cnt++; if (col_idx !== 2'd0) $display("FAIL fips_idx got %0d want 0", col_idx); else pass_cnt++;
    total_cnt++; if (col_ready !== 1'b0) $display("FAIL fips_ready got %b want 0", col_ready); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (state_valid !== 1'b0) $display("FAIL fips_drop got %b want 0", state_valid); else pass_cnt++;
  endtask

  task automatic test_bypass();
    state_ready = 1'b1;
    send4(byp[0], byp[1], byp[2], byp[3], 4'd0);
    total_cnt++; if (state_valid !== 1'b1) $display("FAIL byp_valid got %b want 1", state_valid); else pass_cnt++;
    total_cnt++; if (state_out !== BYP_OUT) $display("FAIL byp_out got %h want %h", state_out, BYP_OUT); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bad_out = 0;
    int bad_rdy = 0;
    int bad_idx = 0;
    int bad_vld = 0;
    state_ready = 1'b0;
    send4(fips[0], fips[1], fips[2], fips[3], 4'd1);
    for (int i = 0; i < 10; i++) begin
      col_valid = 1'b1;
      col_in = $urandom;
      Round = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (state_out !== FIPS_OUT) bad_out++;
      if (col_ready !== 1'b0) bad_rdy++;
      if (col_idx !== 2'd0) bad_idx++;
      if (state_valid !== 1'b1) bad_vld++;
    end
    total_cnt++; if (bad_out != 0) $display("FAIL bp_stable_out got %0d changed cycles want 0", bad_out); else pass_cnt++;
    total_cnt++; if (bad_rdy != 0) $display("FAIL bp_ready got %0d high cycles want 0", bad_rdy); else pass_cnt++;
    total_cnt++; if (bad_idx != 0) $display("FAIL bp_idx got %0d moved cycles want 0", bad_idx); else pass_cnt++;
    total_cnt++; if (bad_vld != 0) $display("FAIL bp_valid got %0d low cycles want 0", bad_vld); else pass_cnt++;
    col_valid = 1'b0;
    state_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (col_ready !== 1'b1) $display("FAIL bp_release got %b want 1", col_ready); else pass_cnt++;
    send4(byp[0], byp[1], byp[2], byp[3], 4'd0);
    total_cnt++; if (state_out !== BYP_OUT) $display("FAIL bp_next_out got %h want %h", state_out, BYP_OUT); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_round_latch_bubbles();
    int early = 0;
    state_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      col_valid = 1'b1;
      col_in = fips[i];
      Round = (i < 2) ? 4'd1 : 4'd0;
      @(negedge clk);
      if (i < 3) begin
        col_valid = 1'b0;
        col_in = 32'hdeadbeef;
        @(negedge clk);
        if (state_valid !== 1'b0) early++;
        total_cnt++; if (col_idx !== 2'(i + 1)) $display("FAIL bub_idx got %0d want %0d", col_idx, i + 1); else pass_cnt++;
      end
    end
    col_valid = 1'b0;
    total_cnt++; if (early != 0) $display("FAIL bub_early got %0d early valids want 0", early); else pass_cnt++;
    total_cnt++; if (state_valid !== 1'b1) $display("FAIL bub_valid got %b want 1", state_valid); else pass_cnt++;
    total_cnt++; if (state_out !== FIPS_OUT) $display("FAIL bub_out got %h want %h", state_out, FIPS_OUT); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nvalid = 0;
    logic [127:0] got = '0;
    state_ready = 1'b1;
    col_valid = 1'b1;
    col_in = byp[0];
    Round = 4'd1;
    @(negedge clk);
    col_in = byp[1];
    @(negedge clk);
    col_in = byp[2];
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    col_valid = 1'b0;
    total_cnt++; if (state_out !== 128'h0) $display("FAIL rmid_out got %h want %h", state_out, 128'h0); else pass_cnt++;
    total_cnt++; if (col_idx !== 2'd0) $display("FAIL rmid_idx got %0d want 0", col_idx); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      col_valid = 1'b1;
      col_in = fips[i];
      Round = 4'd1;
      @(negedge clk);
      if (state_valid === 1'b1) begin nvalid++; got = state_out; end
    end
    col_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (state_valid === 1'b1) nvalid++;
    end
    total_cnt++; if (nvalid != 1) $display("FAIL rmid_count got %0d want 1", nvalid); else pass_cnt++;
    total_cnt++; if (got !== FIPS_OUT) $display("FAIL rmid_out2 got %h want %h", got, FIPS_OUT); else pass_cnt++;
  endtask

  task automatic test_reset_full();
    state_ready = 1'b0;
    send4(byp[0], byp[1], byp[2], byp[3], 4'd0);
    col_valid = 1'b1;
    col_in = 32'h12345678;
    state_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    col_valid = 1'b0;
    total_cnt++; if (state_valid !== 1'b0) $display("FAIL rfull_valid got %b want 0", state_valid); else pass_cnt++;
    total_cnt++; if (col_idx !== 2'd0) $display("FAIL rfull_idx got %0d want 0", col_idx); else pass_cnt++;
    total_cnt++; if (state_out !== 128'h0) $display("FAIL rfull_out got %h want %h", state_out, 128'h0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ptr = 0;
    int first = -1;
    int second = -1;
    int nvalid = 0;
    int bad = 0;
    state_ready = 1'b1;
    Round = 4'd1;
    for (int n = 0; n < 14; n++) begin
      if (state_valid === 1'b1) begin
        nvalid++;
        if (state_out !== FIPS_OUT) bad++;
        if (first < 0) first = n; else if (second < 0) second = n;
      end
      col_valid = (ptr < 8);
      col_in = fips[ptr % 4];
      if (col_ready && col_valid) ptr++;
      @(negedge clk);
    end
    col_valid = 1'b0;
    total_cnt++; if (nvalid != 2) $display("FAIL b2b_count got %0d want 2", nvalid); else pass_cnt++;
    total_cnt++; if (bad != 0) $display("FAIL b2b_out got %0d wrong results want 0", bad); else pass_cnt++;
    total_cnt++; if (first != 4) $display("FAIL b2b_first got %0d want 4", first); else pass_cnt++;
    total_cnt++; if (second - first != 5) $display("FAIL b2b_gap got %0d want 5", second - first); else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fips();
    test_bypass();
    test_backpressure();
    test_round_latch_bubbles();
    do_reset();
    test_reset_mid();
    test_reset_full();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/shiftrows_gather.md
SHIFTROWS_GATHER -- requirements
Module: shiftrows_gather

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; these are the `clk` and `rst_n` ports below.
REQ-002 The block SHALL have no parameters; all widths are fixed by AES-128.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 col_in  input  32  one state column; byte [31:24] is row 0, byte [7:0] is row 3.
REQ-006 col_valid  input  1  col_in is valid this cycle.
REQ-007 col_ready  output  1  block accepts a column this cycle.
REQ-008 Round  input  4  round number; 0 means bypass and no shift.
REQ-009 state_out  output  128  assembled state; column c occupies bits [127-32c : 96-32c].
REQ-010 state_valid  output  1  state_out holds a complete result.
REQ-011 state_ready  input  1  downstream consumes state_out this cycle.
REQ-012 col_idx  output  2  index (0..3) of the next column to be accepted.

Function
REQ-013 The block SHALL accept a column on each rising edge where col_valid and col_ready are both 1 (an accept).
- Column k is written into buffer slot col_idx.
- col_idx then increments, wrapping 3 -> 0.
REQ-014 Round SHALL be sampled and latched only on the accept of column 0; Round changes while columns 1..3 are collected SHALL be ignored.
REQ-015 The FSM SHALL have two states, COLLECT and FULL.
- COLLECT: col_ready = 1, state_valid = 0.
- FULL: col_ready = 0, state_valid = 1.
REQ-016 COLLECT -> FULL SHALL occur on the accept of column 3.
- state_valid rises in the cycle after that accept (1-cycle latency).
REQ-017 FULL -> COLLECT SHALL occur on a rising edge with state_ready = 1.
- col_idx is already 0 at that point.
- A new column can be accepted the cycle after the handshake; peak throughput is one state per 5 cycles.
REQ-018 While in FULL, state_out and state_valid SHALL hold stable until state_ready = 1, independent of col_valid, col_in and Round.
REQ-019 With latched Round != 0, state_out SHALL apply forward ShiftRows to the buffered matrix: out[r][c] = buf[r][(c+r) mod 4].
- For column 0 this gives {buf[127:120], buf[87:80], buf[47:40], buf[7:0]}.
REQ-020 With latched Round == 0, state_out SHALL equal the buffered columns unshifted, in arrival order.
REQ-021 The shift SHALL be realised combinationally from the buffer and the latched Round, or registered at the FULL transition; either way, REQ-016 latency and REQ-018 stability SHALL hold.
REQ-022 In COLLECT, state_out SHALL be don't-care but X-free: it SHALL reflect current buffer contents, never uninitialised storage after reset.
REQ-023 col_valid = 1 while col_ready = 0 SHALL be ignored: no buffer write and no col_idx change.
REQ-024 Bubbles (col_valid = 0) between columns SHALL be allowed without loss or reordering.

Reset
REQ-025 When rst_n = 0 at a rising edge, the block SHALL set:
- state to COLLECT;
- col_idx to 0;
- state_valid to 0, and col_ready to 1 once rst_n = 1;
- buffer to all-zero, so state_out = 128'h0;
- latched Round to 0.
REQ-026 Reset mid-collection or while in FULL SHALL discard the partial or pending state.
- No state_valid pulse is produced for the discarded state.
- The next accepted column is treated as column 0.
REQ-027 Reset SHALL take priority over any simultaneous accept or state_ready handshake.

Verification
REQ-028 FIPS-197 Appendix B, round 1, no backpressure:
- Stimulus: Round = 1, columns d42711ae, e0bf98f1, b8b45de5, 1e415230 on four consecutive cycles, state_ready = 1.
- Response: state_valid = 1 one cycle after the last column; state_out = d4bf5d30e0b452aeb84111f11e2798e5; col_idx returns to 0.
REQ-029 Bypass:
- Stimulus: Round = 0, columns 00112233, 44556677, 8899aabb, ccddeeff.
- Response: state_out = 00112233445566778899aabbccddeeff.
REQ-030 Backpressure:
- Stimulus: state_ready held 0 for 10 cycles after FULL, with col_valid = 1 and random col_in throughout.
- Response: state_out is unchanged, col_ready = 0, and no extra column is accepted; the next state uses only columns sent after the handshake.
REQ-031 Round latching and bubbles:
- Stimulus: Round = 1 at column 0, switched to 0 before column 2; one idle cycle inserted between each column.
- Response: shifted output identical to REQ-028.
REQ-032 Reset mid-collection:
- Stimulus: rst_n = 0 for 1 cycle after 2 columns, then the full REQ-028 sequence.
- Response: exactly one state_valid, with the REQ-028 result; state_out = 0 and col_idx = 0 immediately after reset.
REQ-033 Back-to-back:
- Stimulus: two REQ-028 states streamed, with state_ready = 1 permanently.
- Response: two identical results, 5 cycles apart.
